// File: rtl/i2c_resp_pkg.sv
// Shared types and constants for the I2C target responder.
// Holds the protocol FSM state type, the ACK/NACK bit levels and the synchronizer depth.
package i2c_resp_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } state_t;

    localparam logic BIT_ACK     = 1'b0;
    localparam logic BIT_NACK    = 1'b1;
    localparam int   SYNC_STAGES = 2;

endpackage

// File: rtl/i2c_bus_sync.sv
// Bus synchronizer: filtered SCL/SDA levels plus SCL edge and START/STOP pulses.
// Pulses appear 2 clk after a pin change; free-running, no backpressure.
module i2c_bus_sync
    import i2c_resp_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_scl,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;
    logic                   w_scl;
    logic                   w_sda;

    // Idle bus is pulled high, so reset the whole chain to 1 to avoid spurious edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
        end
    end

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign o_scl      = w_scl;
    assign o_sda      = w_sda;
    assign o_scl_rise = w_scl & ~r_scl_d;
    assign o_scl_fall = ~w_scl & r_scl_d;
    assign o_start    = w_scl & r_scl_d & ~w_sda & r_sda_d;
    assign o_stop     = w_scl & r_scl_d & w_sda & ~r_sda_d;

endmodule

// File: rtl/i2c_target_responder.sv
// I2C target with an auto-incrementing byte register bank, open-drain SDA.
// SDA changes 3 clk after an SCL fall at the pins; the bus master paces everything.
module i2c_target_responder
    import i2c_resp_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         REG_COUNT   = 16,
    localparam int        PTR_W       = $clog2(REG_COUNT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i2c_scl_i,
    input  logic             i2c_sda_i,
    output logic             i2c_sda_o,
    output logic             i2c_sda_t,
    output logic             reg_wr_valid,
    output logic [PTR_W-1:0] reg_wr_addr,
    output logic [7:0]       reg_wr_data,
    output logic             busy,
    output logic             nack_seen
);

    logic w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

    i2c_bus_sync u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_scl      (i2c_scl_i),
        .i_sda      (i2c_sda_i),
        .o_scl      (w_scl),
        .o_sda      (w_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    state_t           r_state,    w_state_nxt;
    logic [2:0]       r_cnt,      w_cnt_nxt;
    logic [7:0]       r_shift,    w_shift_nxt;
    logic [PTR_W-1:0] r_ptr,      w_ptr_nxt;
    logic             r_rw,       w_rw_nxt;
    logic             r_phase,    w_phase_nxt;
    logic             r_sda_t,    w_sda_t_nxt;
    logic             r_busy,     w_busy_nxt;
    logic             r_wr_vld,   w_wr_vld_nxt;
    logic [PTR_W-1:0] r_wr_addr,  w_wr_addr_nxt;
    logic [7:0]       r_wr_data,  w_wr_data_nxt;
    logic             r_nack,     w_nack_nxt;
    logic [7:0]       r_regs [REG_COUNT];

    logic [7:0]       w_byte;
    logic [PTR_W-1:0] w_ptr_inc;
    logic             w_drive;

    assign w_byte    = {r_shift[6:0], w_sda};
    assign w_ptr_inc = r_ptr + 1'b1;
    assign w_drive   = w_scl_fall & ~w_scl;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_shift_nxt   = r_shift;
        w_ptr_nxt     = r_ptr;
        w_rw_nxt      = r_rw;
        w_phase_nxt   = r_phase;
        w_sda_t_nxt   = r_sda_t;
        w_busy_nxt    = r_busy;
        w_wr_vld_nxt  = 1'b0;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        w_nack_nxt    = 1'b0;

        if (w_start) begin
            w_state_nxt = ST_ADDR;
            w_cnt_nxt   = 3'd0;
            w_phase_nxt = 1'b0;
            w_sda_t_nxt = 1'b1;
        end else if (w_stop) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 3'd0;
            w_phase_nxt = 1'b0;
            w_sda_t_nxt = 1'b1;
            w_busy_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = w_byte;
                        w_cnt_nxt   = r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            if (r_state == ST_ADDR) begin
                                // General call (address 0) is never claimed.
                                if (w_byte[7:1] == TARGET_ADDR && w_byte[7:1] != 7'd0) begin
                                    w_state_nxt = ST_ADDR_ACK;
                                    w_busy_nxt  = 1'b1;
                                    w_rw_nxt    = w_byte[0];
                                end else begin
                                    w_state_nxt = ST_IGNORE;
                                end
                            end else if (r_state == ST_PTR) begin
                                w_ptr_nxt   = w_byte[PTR_W-1:0];
                                w_state_nxt = ST_PTR_ACK;
                            end else begin
                                w_wr_vld_nxt  = 1'b1;
                                w_wr_addr_nxt = r_ptr;
                                w_wr_data_nxt = w_byte;
                                w_ptr_nxt     = w_ptr_inc;
                                w_state_nxt   = ST_WDATA_ACK;
                            end
                        end
                    end
                end
                // phase 0: first fall starts the ACK pull-down; phase 1: next fall ends it.
                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (w_drive) begin
                        if (!r_phase) begin
                            w_sda_t_nxt = BIT_ACK;
                            w_phase_nxt = 1'b1;
                        end else begin
                            w_sda_t_nxt = 1'b1;
                            w_phase_nxt = 1'b0;
                            w_cnt_nxt   = 3'd0;
                            if (r_state == ST_ADDR_ACK && r_rw) begin
                                w_shift_nxt = r_regs[r_ptr];
                                w_sda_t_nxt = r_regs[r_ptr][7];
                                w_state_nxt = ST_RDATA;
                            end else if (r_state == ST_ADDR_ACK) begin
                                w_state_nxt = ST_PTR;
                            end else begin
                                w_state_nxt = ST_WDATA;
                            end
                        end
                    end
                end
                // shift[7] always holds the bit to drive on the next fall.
                ST_RDATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = {r_shift[6:0], 1'b0};
                        w_cnt_nxt   = r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            w_phase_nxt = 1'b1;
                        end
                    end else if (w_drive) begin
                        if (r_phase) begin
                            w_sda_t_nxt = 1'b1;
                            w_phase_nxt = 1'b0;
                            w_state_nxt = ST_RDATA_ACK;
                        end else begin
                            w_sda_t_nxt = r_shift[7];
                        end
                    end
                end
                ST_RDATA_ACK: begin
                    if (w_scl_rise) begin
                        if (w_sda == BIT_ACK) begin
                            w_ptr_nxt   = w_ptr_inc;
                            w_shift_nxt = r_regs[w_ptr_inc];
                            w_cnt_nxt   = 3'd0;
                            w_state_nxt = ST_RDATA;
                        end else begin
                            w_nack_nxt  = 1'b1;
                            w_state_nxt = ST_IGNORE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 3'd0;
            r_shift   <= 8'h00;
            r_ptr     <= '0;
            r_rw      <= 1'b0;
            r_phase   <= 1'b0;
            r_sda_t   <= 1'b1;
            r_busy    <= 1'b0;
            r_wr_vld  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= 8'h00;
            r_nack    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_ptr     <= w_ptr_nxt;
            r_rw      <= w_rw_nxt;
            r_phase   <= w_phase_nxt;
            r_sda_t   <= w_sda_t_nxt;
            r_busy    <= w_busy_nxt;
            r_wr_vld  <= w_wr_vld_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_nack    <= w_nack_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else if (w_wr_vld_nxt) begin
            r_regs[r_ptr] <= w_byte;
        end
    end

    assign i2c_sda_o    = 1'b0;
    assign i2c_sda_t    = r_sda_t;
    assign reg_wr_valid = r_wr_vld;
    assign reg_wr_addr  = r_wr_addr;
    assign reg_wr_data  = r_wr_data;
    assign busy         = r_busy;
    assign nack_seen    = r_nack;

endmodule

// File: tb/tb_i2c_target_responder.sv
// Bench for i2c_target_responder: bit-level I2C master, register-bank reference model.
// Directed table of address vectors, hand-written corner sequences, then randomized traffic.
module tb_i2c_target_responder;

    localparam int REGN = 16;
    localparam int Q    = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_o, sda_t, wr_vld, busy, nack;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       bus_sda;

    assign bus_sda = m_sda & (sda_t | sda_o);

    i2c_target_responder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i2c_scl_i    (m_scl),
        .i2c_sda_i    (bus_sda),
        .i2c_sda_o    (sda_o),
        .i2c_sda_t    (sda_t),
        .reg_wr_valid (wr_vld),
        .reg_wr_addr  (wr_addr),
        .reg_wr_data  (wr_data),
        .busy         (busy),
        .nack_seen    (nack)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  mdl_regs [REGN];
    int          mdl_ptr = 0;
    logic [11:0] wr_q [$];
    int          nack_cnt = 0;
    bit          sda_low_seen = 0;
    int          sda_viol = 0;
    logic        scl_p = 1'b1;
    logic        sdat_p = 1'b1;

    always @(posedge clk) begin
        #1;
        if (wr_vld) wr_q.push_back({wr_addr, wr_data});
        if (nack) nack_cnt++;
        if (!sda_t) sda_low_seen = 1;
        if (rst_n && m_scl && scl_p && (sda_t !== sdat_p)) sda_viol++;
        scl_p  = m_scl;
        sdat_p = sda_t;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic bus_start();
        m_sda = 1'b1; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        m_sda = 1'b0; wait_clk(Q);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        m_sda = 1'b1; wait_clk(2*Q);
    endtask

    task automatic bus_bit(input logic b, output logic s);
        m_sda = b;    wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        s = bus_sda;  wait_clk(Q);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
        bus_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic recv_byte(input logic ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            d[i] = s;
        end
        bus_bit(ack ? 1'b0 : 1'b1, s);
    endtask

    // Write n bytes (d[3] first) starting at pointer p, checking ACKs, busy and commit pulses.
    task automatic wr_txn(input logic [7:0] p, input int n, input logic [3:0][7:0] d, input string nm);
        logic        ack;
        logic [11:0] exp_q [$];
        wr_q.delete();
        bus_start();
        send_byte(8'hA0, ack);
        chk({nm, "_addr_ack"}, ack, 1);
        chk({nm, "_busy"}, busy, 1);
        send_byte(p, ack);
        chk({nm, "_ptr_ack"}, ack, 1);
        mdl_ptr = p % REGN;
        for (int i = 0; i < n; i++) begin
            send_byte(d[3-i], ack);
            chk({nm, "_data_ack"}, ack, 1);
            mdl_regs[mdl_ptr] = d[3-i];
            exp_q.push_back({4'(mdl_ptr), d[3-i]});
            mdl_ptr = (mdl_ptr + 1) % REGN;
        end
        bus_stop();
        chk({nm, "_busy_after_stop"}, busy, 0);
        chk({nm, "_wr_count"}, wr_q.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < wr_q.size()) chk({nm, "_wr_event"}, wr_q[i], exp_q[i]);
        end
    endtask

    // Read n bytes (ACK all but the last), optionally setting the pointer first via a repeated START.
    task automatic rd_txn(input logic [7:0] p, input bit setp, input int n, input string nm);
        logic       ack;
        logic [7:0] d;
        int         nack0;
        nack0 = nack_cnt;
        bus_start();
        if (setp) begin
            send_byte(8'hA0, ack);
            chk({nm, "_waddr_ack"}, ack, 1);
            send_byte(p, ack);
            chk({nm, "_ptr_ack"}, ack, 1);
            mdl_ptr = p % REGN;
            bus_start();
        end
        send_byte(8'hA1, ack);
        chk({nm, "_raddr_ack"}, ack, 1);
        for (int i = 0; i < n; i++) begin
            recv_byte(i < n - 1, d);
            chk({nm, "_rdata"}, d, mdl_regs[mdl_ptr]);
            if (i < n - 1) mdl_ptr = (mdl_ptr + 1) % REGN;
        end
        chk({nm, "_released"}, sda_t, 1);
        chk({nm, "_nack_pulses"}, nack_cnt - nack0, 1);
        bus_stop();
        chk({nm, "_busy_after_stop"}, busy, 0);
    endtask

    typedef struct {
        logic [7:0] addr;
        logic       exp_ack;
    } vec_t;

    initial begin
        vec_t       vt [7];
        logic       ack, s;
        logic [7:0] d;
        int         k;

        vt[0] = '{8'hA0, 1'b1};
        vt[1] = '{8'hA1, 1'b1};
        vt[2] = '{8'hA2, 1'b0};
        vt[3] = '{8'h00, 1'b0};
        vt[4] = '{8'h20, 1'b0};
        vt[5] = '{8'hFF, 1'b0};
        vt[6] = '{8'hA3, 1'b0};
        for (int i = 0; i < REGN; i++) mdl_regs[i] = 8'h00;

        wait_clk(3);
        chk("rst_sda_t", sda_t, 1);
        chk("rst_sda_o", sda_o, 0);
        chk("rst_wr_valid", wr_vld, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_nack", nack, 0);
        rst_n = 1'b1;
        wait_clk(4);

        wr_txn(8'h03, 2, {8'hA5, 8'h5A, 8'h00, 8'h00}, "write");
        rd_txn(8'h03, 1'b1, 2, "read");

        for (int v = 0; v < 7; v++) begin
            sda_low_seen = 0;
            bus_start();
            send_byte(vt[v].addr, ack);
            chk("tbl_ack", ack, vt[v].exp_ack);
            chk("tbl_busy", busy, vt[v].exp_ack);
            if (ack && vt[v].addr[0]) begin
                recv_byte(1'b0, d);
                chk("tbl_rdata", d, mdl_regs[mdl_ptr]);
            end
            bus_stop();
            chk("tbl_sda_driven", sda_low_seen, vt[v].exp_ack);
            chk("tbl_busy_end", busy, 0);
        end

        sda_low_seen = 0;
        wr_q.delete();
        bus_start();
        send_byte(8'hA2, ack);
        send_byte(8'h00, ack);
        chk("miss_busy", busy, 0);
        bus_stop();
        chk("miss_sda_driven", sda_low_seen, 0);
        chk("miss_wr_count", wr_q.size(), 0);

        wr_txn(8'h0F, 2, {8'h11, 8'h22, 8'h00, 8'h00}, "wrap_wr");
        rd_txn(8'h0F, 1'b1, 2, "wrap_rd");

        bus_start();
        send_byte(8'hA0, ack);
        send_byte(8'h03, ack);
        bus_start();
        send_byte(8'hA1, ack);
        chk("rstmid_addr_ack", ack, 1);
        bus_bit(1'b1, s);
        chk("rstmid_bit7", s, 1);
        k = 0;
        while (sda_t && k < 20) begin
            wait_clk(1);
            k++;
        end
        chk("rstmid_driving0", sda_t, 0);
        rst_n = 1'b0;
        #1;
        chk("rstmid_async_release", sda_t, 1);
        chk("rstmid_busy", busy, 0);
        for (int i = 0; i < REGN; i++) mdl_regs[i] = 8'h00;
        mdl_ptr = 0;
        wait_clk(3);
        rst_n = 1'b1;
        sda_low_seen = 0;
        wr_q.delete();
        for (int i = 0; i < 12; i++) bus_bit(1'($urandom_range(0, 1)), s);
        chk("rstmid_ignore_sda", sda_low_seen, 0);
        chk("rstmid_ignore_wr", wr_q.size(), 0);
        chk("rstmid_ignore_busy", busy, 0);
        bus_stop();
        rd_txn(8'h00, 1'b0, 1, "rstmid_ptr0");
        rd_txn(8'h03, 1'b1, 2, "rstmid_cleared");

        wr_q.delete();
        bus_start();
        send_byte(8'hA0, ack);
        send_byte(8'h05, ack);
        mdl_ptr = 5;
        for (int i = 0; i < 5; i++) bus_bit(1'(i % 2), s);
        bus_stop();
        chk("trunc_wr_count", wr_q.size(), 0);
        chk("trunc_busy", busy, 0);
        wr_txn(8'h05, 1, {8'h3C, 8'h00, 8'h00, 8'h00}, "trunc_next_wr");
        rd_txn(8'h05, 1'b1, 1, "trunc_next_rd");

        for (int it = 0; it < 12; it++) begin
            logic [3:0][7:0] rd;
            for (int j = 0; j < 4; j++) rd[j] = 8'($urandom_range(0, 255));
            wr_txn(8'($urandom_range(0, 255)), $urandom_range(1, 4), rd, "rand_wr");
            rd_txn(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), $urandom_range(1, 4), "rand_rd");
        end

        chk("sda_change_while_scl_high", sda_viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
